expr_pipe: RTL and testbench
============================

EXPR_PIPE -- requirements
Module: expr_pipe

Interface
REQ-001 SHALL have parameter W, default 6, giving the operand width per lane (legal 2..16).
REQ-002 SHALL have parameter LANES, default 3, giving the number of independent operand lanes (legal 1..8).
REQ-003 SHALL have parameter DEPTH, default 2, giving the number of pipeline stages (legal 1..4).
REQ-004 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: the input beat is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts an input beat this cycle.
REQ-008 SHALL have port op, input, 3 bits: operation code, shared by all lanes of the beat.
REQ-009 SHALL have port a, input, LANES*W bits: unsigned operands; lane i occupies bits [i*W +: W].
REQ-010 SHALL have port b, input, LANES*W bits: signed two's-complement operands, packed the same way as a.
REQ-011 SHALL have port out_valid, output, 1 bit: the output beat is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the output beat.
REQ-013 SHALL have port y, output, LANES*(W+2) bits: signed per-lane results; lane i occupies bits [i*(W+2) +: W+2].
REQ-014 SHALL have port zflag, output, LANES bits: zflag[i] is 1 when lane i of y is zero.
REQ-015 SHALL have port count, output, 16 bits: number of completed output handshakes.

Function
REQ-016 SHALL operate on each lane with a zero-extended and b sign-extended to W+2 bits, using the ops below.
- 0: a+b
- 1: a-b
- 2: a&b
- 3: ~(a^b)
- 4: ({0,a} < b) as 0/1
- 5: reduction XOR of {a,b} as 0/1
- 6: a << b[2:0], truncated to W+2 bits
- 7: (a == b[W-1:0] bit pattern) as 0/1
REQ-017 SHALL accept an input beat when in_valid && in_ready, and complete an output beat when out_valid && out_ready.
REQ-018 SHALL compute in stage 1; stages 2..DEPTH only carry the result forward; an unstalled beat appears on y exactly DEPTH cycles after it is accepted.
REQ-019 SHALL advance each stage when the next stage is empty or also advancing, giving full throughput of one beat per cycle with out_ready held high.
REQ-020 SHALL drive in_ready = (stage 1 empty) or (stage 1 advances this cycle), with no combinational path from in_valid to in_ready.
REQ-021 SHALL hold y, zflag and out_valid stable while out_valid && !out_ready; beats are never dropped, duplicated or reordered.
REQ-022 SHALL increment count once per output handshake, wrapping from 0xFFFF to 0x0000.
REQ-023 SHALL be able to accept a new input beat and complete an output beat in the same cycle with the pipeline full, leaving occupancy unchanged.

Reset
REQ-024 SHALL, while rst is high at a clock edge, clear every stage-valid bit, y to 0, zflag to 0 and count to 0.
REQ-025 SHALL drive in_ready = 0 during a reset cycle and in_ready = 1 in the first cycle after rst falls.
REQ-026 SHALL discard in-flight beats on a mid-operation reset, with no output handshake and no count change for them.

Configuration
REQ-027 SHALL, when macro EXPR_PIPE_SAT_EN is defined, clamp the op 0 and op 1 results to the W-bit signed range [-2^(W-1), 2^(W-1)-1], sign-extended to W+2 bits.
REQ-028 SHALL, when EXPR_PIPE_SAT_EN is undefined, return the exact W+2-bit op 0 and op 1 results with no clamping; all other ops are identical in both builds.

Verification (W=6, LANES=3, DEPTH=2)
REQ-029 SHALL cover: op=0, lane0 a=63, b=31, out_ready=1 -> y lane0 = 94 (no macro) or 31 (EXPR_PIPE_SAT_EN) two cycles later; count=1.
REQ-030 SHALL cover: op=1, a=0, b=-32 -> y = 32 (no macro) or 31 (macro); op=1, a=5, b=5 -> y=0 and zflag bit set.
REQ-031 SHALL cover: op=6, a=3, b=2 -> 12; op=4, a=1, b=-1 -> 0; op=5, a=1, b=0 -> 1; op=7, a=63, b=-1 -> 1.
REQ-032 SHALL cover: out_ready=0 with 4 beats offered back-to-back -> exactly 2 accepted, then in_ready=0; after out_ready=1, all 4 beats emerge in order, one per cycle, count +4.
REQ-033 SHALL cover: count preloaded to 0xFFFF via 65535 handshakes, then one more handshake -> count=0x0000.
REQ-034 SHALL cover: rst asserted with 2 beats in flight -> next cycle out_valid=0, y=0, count=0, in_ready=0; the cycle after rst falls, in_ready=1.

Source files
------------

// File: rtl/expr_pipe.sv
// Multi-lane expression pipeline: per-lane ALU in stage 1, then DEPTH-1 carry stages
// with valid/ready flow control. Optional saturation of add/sub: define EXPR_PIPE_SAT_EN.
module expr_pipe #(
    parameter int W     = 6,
    parameter int LANES = 3,
    parameter int DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [2:0]                op,
    input  logic [LANES*W-1:0]        a,
    input  logic [LANES*W-1:0]        b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*(W+2)-1:0]    y,
    output logic [LANES-1:0]          zflag,
    output logic [15:0]               count
);

    localparam int RW = W + 2;
    localparam int YW = LANES * RW;

`ifdef EXPR_PIPE_SAT_EN
    localparam logic [RW-1:0] SAT_HI = {3'b000, {(W-1){1'b1}}};
    localparam logic [RW-1:0] SAT_LO = {3'b111, {(W-1){1'b0}}};
`endif

    function automatic logic [RW-1:0] lane_calc(input logic [2:0]   f_op,
                                                input logic [W-1:0] f_a,
                                                input logic [W-1:0] f_b);
        logic [RW-1:0] ax;
        logic [RW-1:0] bx;
        logic [RW-1:0] r;
        ax = {2'b00, f_a};
        bx = {{2{f_b[W-1]}}, f_b};
        case (f_op)
            3'd0:    r = ax + bx;
            3'd1:    r = ax - bx;
            3'd2:    r = ax & bx;
            3'd3:    r = ~(ax ^ bx);
            3'd4:    r = {{(RW-1){1'b0}}, ($signed(ax) < $signed(bx))};
            3'd5:    r = {{(RW-1){1'b0}}, ^{f_a, f_b}};
            3'd6:    r = ax << f_b[2:0];
            default: r = {{(RW-1){1'b0}}, (f_a == f_b)};
        endcase
`ifdef EXPR_PIPE_SAT_EN
        if (f_op == 3'd0 || f_op == 3'd1) begin
            if ($signed(r) > $signed(SAT_HI)) begin
                r = SAT_HI;
            end else if ($signed(r) < $signed(SAT_LO)) begin
                r = SAT_LO;
            end
        end
`endif
        return r;
    endfunction

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [YW-1:0]    dat_q [DEPTH];
    logic [YW-1:0]    dat_d [DEPTH];
    logic [LANES-1:0] zf_q  [DEPTH];
    logic [LANES-1:0] zf_d  [DEPTH];
    logic [15:0]      count_q, count_d;

    logic [YW-1:0]    calc_y;
    logic [LANES-1:0] calc_z;
    logic [DEPTH:0]   rdy_n;
    logic [DEPTH-1:0] adv;
    logic             all_full;
    logic             take;
    logic             give;

    always_comb begin
        calc_y = '0;
        calc_z = '0;
        for (int l = 0; l < LANES; l++) begin
            calc_y[l*RW +: RW] = lane_calc(op, a[l*W +: W], b[l*W +: W]);
            calc_z[l]          = (calc_y[l*RW +: RW] == '0);
        end
    end

    // A stage can take a beat unless it and everything downstream is full
    // and the consumer is stalling; this keeps in_ready independent of in_valid.
    always_comb begin
        all_full     = 1'b1;
        rdy_n        = '0;
        rdy_n[DEPTH] = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            all_full = all_full & vld_q[k];
            rdy_n[k] = ~all_full | out_ready;
        end
        adv = '0;
        for (int k = 0; k < DEPTH; k++) begin
            adv[k] = vld_q[k] & rdy_n[k+1];
        end
    end

    assign in_ready  = rdy_n[0] & ~rst;
    assign out_valid = vld_q[DEPTH-1] & ~rst;
    assign y         = dat_q[DEPTH-1];
    assign zflag     = zf_q[DEPTH-1];
    assign count     = count_q;

    assign take = in_valid & in_ready;
    assign give = out_valid & out_ready;

    always_comb begin
        vld_d   = vld_q;
        dat_d   = dat_q;
        zf_d    = zf_q;
        count_d = count_q;

        vld_d[0] = take | (vld_q[0] & ~adv[0]);
        if (take) begin
            dat_d[0] = calc_y;
            zf_d[0]  = calc_z;
        end
        for (int k = 1; k < DEPTH; k++) begin
            vld_d[k] = adv[k-1] | (vld_q[k] & ~adv[k]);
            if (adv[k-1]) begin
                dat_d[k] = dat_q[k-1];
                zf_d[k]  = zf_q[k-1];
            end
        end

        if (give) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q   <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= '0;
                zf_q[k]  <= '0;
            end
        end else begin
            vld_q   <= vld_d;
            count_q <= count_d;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= dat_d[k];
                zf_q[k]  <= zf_d[k];
            end
        end
    end

endmodule

// File: tb/tb_expr_pipe.sv
// Randomized bench for expr_pipe against an integer-arithmetic reference model
// and a queue of expected beats; honours EXPR_PIPE_SAT_EN when defined.
module tb_expr_pipe;

    localparam int W     = 6;
    localparam int LANES = 3;
    localparam int DEPTH = 2;
    localparam int RW    = W + 2;
    localparam int AW    = LANES * W;
    localparam int YW    = LANES * RW;
    localparam int NOK   = -1000;

`ifdef EXPR_PIPE_SAT_EN
    localparam int K_ADD = 31;
    localparam int K_SUB = 31;
`else
    localparam int K_ADD = 94;
    localparam int K_SUB = 32;
`endif

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [AW-1:0]   a;
    logic [AW-1:0]   b;
    logic            out_valid;
    logic            out_ready;
    logic [YW-1:0]   y;
    logic [LANES-1:0] zflag;
    logic [15:0]     count;

    expr_pipe #(.W(W), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zflag     (zflag),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [YW-1:0]    y;
        logic [LANES-1:0] z;
        int               cyc;
        int               k;
    } beat_t;

    typedef struct {
        logic [2:0]   o;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        int           k;
    } dir_t;

    beat_t       q[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [15:0] exp_count = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // a is 0..2^W-1, b is -2^(W-1)..2^(W-1)-1; plain integer arithmetic.
    function automatic int ref_lane(input int o, input int av, input int bv);
        int r;
        case (o)
            0: r = av + bv;
            1: r = av - bv;
            2: r = av & bv;
            3: r = ~(av ^ bv);
            4: r = (av < bv) ? 1 : 0;
            5: r = ($countones(av) + $countones(bv & ((1 << W) - 1))) % 2;
            6: r = av << (bv & 7);
            default: r = (av == (bv & ((1 << W) - 1))) ? 1 : 0;
        endcase
`ifdef EXPR_PIPE_SAT_EN
        if (o < 2) begin
            if (r > (1 << (W - 1)) - 1) r = (1 << (W - 1)) - 1;
            if (r < -(1 << (W - 1)))    r = -(1 << (W - 1));
        end
`endif
        return r & ((1 << RW) - 1);
    endfunction

    function automatic beat_t make_beat(input logic [2:0] o, input logic [AW-1:0] av,
                                        input logic [AW-1:0] bv);
        beat_t bt;
        int    r;
        int    bs;
        logic [31:0] rv;
        bt.y = '0; bt.z = '0; bt.cyc = 0; bt.k = NOK;
        for (int l = 0; l < LANES; l++) begin
            bs = $signed(bv[l*W +: W]);
            r  = ref_lane(int'(o), int'(av[l*W +: W]), bs);
            rv = r;
            bt.y[l*RW +: RW] = rv[RW-1:0];
            bt.z[l] = (r == 0);
        end
        return bt;
    endfunction

    task automatic step(input logic iv, input logic [2:0] o, input logic [AW-1:0] av,
                        input logic [AW-1:0] bv, input logic ordy, input int k,
                        output logic acc);
        logic  ev_ir;
        logic  ev_ov;
        beat_t bt;
        int    l0;
        @(negedge clk);
        in_valid = iv; op = o; a = av; b = bv; out_ready = ordy;
        #1;
        ev_ir = (q.size() < DEPTH) || ordy;
        ev_ov = 1'b0;
        if (q.size() > 0) ev_ov = (cyc >= q[0].cyc + DEPTH);
        chk("in_ready", {31'd0, in_ready}, {31'd0, ev_ir});
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev_ov});
        chk("count", {16'd0, count}, {16'd0, exp_count});
        if (out_valid && out_ready && q.size() > 0) begin
            bt = q.pop_front();
            chk("y", 32'(y), 32'(bt.y));
            chk("zflag", 32'(zflag), 32'(bt.z));
            if (bt.k != NOK) begin
                l0 = $signed(y[RW-1:0]);
                chk("lane0_value", l0, bt.k);
            end
            exp_count++;
        end
        acc = in_valid && in_ready;
        if (acc) begin
            bt     = make_beat(o, av, bv);
            bt.cyc = cyc;
            bt.k   = k;
            q.push_back(bt);
        end
        cyc++;
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 3'd0, '0, '0, 1'b1, NOK, acc);
        chk("drain", q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          acc;
        dir_t          dt[7];
        logic [AW-1:0] av, bv;
        logic [2:0]    bo[4];
        logic [AW-1:0] ba[4], bb[4];
        logic [15:0]   base;
        int            idx, ii, issued;

        rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_y", 32'(y), 0);
        chk("rst_zflag", 32'(zflag), 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_count", {16'd0, count}, 0);
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 1);

        dt[0] = '{3'd0, 6'd63, 6'd31, K_ADD};
        dt[1] = '{3'd1, 6'd0,  6'h20, K_SUB};
        dt[2] = '{3'd1, 6'd5,  6'd5,  0};
        dt[3] = '{3'd6, 6'd3,  6'd2,  12};
        dt[4] = '{3'd4, 6'd1,  6'h3F, 0};
        dt[5] = '{3'd5, 6'd1,  6'd0,  1};
        dt[6] = '{3'd7, 6'd63, 6'h3F, 1};
        for (int i = 0; i < 7; i++) begin
            av = AW'($urandom); bv = AW'($urandom);
            av[W-1:0] = dt[i].a0; bv[W-1:0] = dt[i].b0;
            step(1'b1, dt[i].o, av, bv, 1'b1, dt[i].k, acc);
            chk("dir_accept", {31'd0, acc}, 1);
        end
        drain();

        // Back-pressure: four beats offered against a stalled consumer.
        for (int i = 0; i < 4; i++) begin
            bo[i] = 3'($urandom); ba[i] = AW'($urandom); bb[i] = AW'($urandom);
        end
        base = exp_count;
        idx  = 0;
        for (int i = 0; i < 4; i++) begin
            ii = (idx < 4) ? idx : 3;
            step(1'b1, bo[ii], ba[ii], bb[ii], 1'b0, NOK, acc);
            if (acc) idx++;
        end
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", {31'd0, in_ready}, 0);
        for (int i = 0; i < 20 && (idx < 4 || q.size() > 0); i++) begin
            ii = (idx < 4) ? idx : 3;
            step(idx < 4, bo[ii], ba[ii], bb[ii], 1'b1, NOK, acc);
            if (acc) idx++;
        end
        @(negedge clk);
        #1;
        chk("bp_count", {16'd0, count}, {16'd0, 16'(base + 16'd4)});

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0), 3'($urandom), AW'($urandom), AW'($urandom),
                 ($urandom_range(0, 9) < 7), NOK, acc);
        end
        drain();

        // Reset with two beats in flight.
        step(1'b1, 3'($urandom), AW'($urandom), AW'($urandom), 1'b0, NOK, acc);
        step(1'b1, 3'($urandom), AW'($urandom), AW'($urandom), 1'b0, NOK, acc);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("mr_in_ready_now", {31'd0, in_ready}, 0);
        chk("mr_out_valid_now", {31'd0, out_valid}, 0);
        @(negedge clk);
        #1;
        chk("mr_out_valid", {31'd0, out_valid}, 0);
        chk("mr_y", 32'(y), 0);
        chk("mr_count", {16'd0, count}, 0);
        chk("mr_in_ready", {31'd0, in_ready}, 0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_in_ready_after", {31'd0, in_ready}, 1);
        q.delete();
        exp_count = '0;

        // Count wrap: exactly 65536 handshakes from zero.
        issued = 0;
        for (int i = 0; i < 70000 && (issued < 65536 || q.size() > 0); i++) begin
            step(issued < 65536, 3'($urandom), AW'($urandom), AW'($urandom), 1'b1, NOK, acc);
            if (acc) issued++;
        end
        chk("wrap_done", {31'd0, (issued == 65536 && q.size() == 0)}, 1);
        @(negedge clk);
        #1;
        chk("wrap_count", {16'd0, count}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
